// File: rtl/multicast_input_unit_pkg.sv
// rtl/multicast_input_unit_pkg.sv - shared constants and types for the multicast input unit
package multicast_input_unit_pkg;

    localparam int PORT_L    = 0;
    localparam int PORT_W    = 1;
    localparam int PORT_N    = 2;
    localparam int PORT_E    = 3;
    localparam int PORT_S    = 4;
    localparam int NUM_PORTS = 5;

    localparam int MESH_DIM  = 4;

    // Destination bitmap occupies the top 16 bits of a flit.
    localparam int BMP_MSB   = 29;
    localparam int BMP_LSB   = 14;

    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } mi_state_e;

    function automatic logic [NUM_PORTS-1:0] port_bit(input int p);
        port_bit = NUM_PORTS'(1) << p;
    endfunction

endpackage

// File: rtl/multicast_input_unit_route_compute.sv
// rtl/multicast_input_unit_route_compute.sv - XY route of a destination bitmap to a 5-bit output-port label
module mi_route_compute
    import multicast_input_unit_pkg::*;
#(
    parameter int router_ID = 6
) (
    input  logic [MESH_DIM*MESH_DIM-1:0] bitmap_i,
    output logic [NUM_PORTS-1:0]         label_o
);

    localparam int MY_X = router_ID % MESH_DIM;
    localparam int MY_Y = router_ID / MESH_DIM;

    // X is resolved first; only destinations in this column route N/S/L.
    always_comb begin
        label_o = '0;
        for (int d = 0; d < MESH_DIM*MESH_DIM; d++) begin
            if (bitmap_i[d]) begin
                if ((d % MESH_DIM) > MY_X)      label_o = label_o | port_bit(PORT_E);
                else if ((d % MESH_DIM) < MY_X) label_o = label_o | port_bit(PORT_W);
                else if ((d / MESH_DIM) < MY_Y) label_o = label_o | port_bit(PORT_N);
                else if ((d / MESH_DIM) > MY_Y) label_o = label_o | port_bit(PORT_S);
                else                            label_o = label_o | port_bit(PORT_L);
            end
        end
    end

endmodule

// File: rtl/multicast_input_unit.sv
// rtl/multicast_input_unit.sv - input FIFO plus multicast label tracking; MI_DROP_CNT_EN adds drop_cnt
module multicast_input_unit
    import multicast_input_unit_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int WIDTH     = 2,
    parameter int DATASIZE  = 30,
    parameter int router_ID = 6
) (
    input  logic                 mi_clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [DATASIZE-1:0]  in_data,
    output logic                 full,
    output logic [4:0]           label_out,
    output logic [DATASIZE-1:0]  data_out,
    output logic                 valid_out,
    input  logic [4:0]           grant
`ifdef MI_DROP_CNT_EN
    ,
    output logic [7:0]           drop_cnt
`endif
);

    localparam logic [WIDTH:0] DEPTH_CNT = (WIDTH+1)'(DEPTH);
    localparam logic [WIDTH:0] ONE_CNT   = (WIDTH+1)'(1);

    logic [DATASIZE-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0]    wr_ptr_q;
    logic [WIDTH-1:0]    rd_ptr_q;
    logic [WIDTH-1:0]    rd_ptr_nxt;
    logic [WIDTH:0]      count_q;
    logic [WIDTH:0]      count_d;
    logic                full_q;
    logic                empty;
    logic                push;
    logic                pop;
    logic                drop;

    mi_state_e           state_q;
    logic [4:0]          label_q;
    logic [4:0]          rem;
    logic [4:0]          head_label;
    logic [4:0]          next_label;

    assign empty      = (count_q == '0);
    assign push       = in_valid && !full_q;
    assign rd_ptr_nxt = rd_ptr_q + WIDTH'(1);
    assign rem        = label_q & ~grant;

    mi_route_compute #(.router_ID(router_ID)) u_route_head (
        .bitmap_i (mem_q[rd_ptr_q][BMP_MSB:BMP_LSB]),
        .label_o  (head_label)
    );

    // Looking one entry ahead lets the next label load on the final grant cycle.
    mi_route_compute #(.router_ID(router_ID)) u_route_next (
        .bitmap_i (mem_q[rd_ptr_nxt][BMP_MSB:BMP_LSB]),
        .label_o  (next_label)
    );

    always_comb begin
        drop = (state_q == IDLE) && !empty && (head_label == '0);
        pop  = drop || ((state_q == SERVE) && (rem == '0));
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + ONE_CNT;
            2'b01:   count_d = count_q - ONE_CNT;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge mi_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    always_ff @(posedge mi_clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + WIDTH'(1);
            if (pop)  rd_ptr_q <= rd_ptr_nxt;
            count_q <= count_d;
            full_q  <= (count_d == DEPTH_CNT);
        end
    end

    // A zero label on the look-ahead entry falls back to IDLE, which drops it.
    always_ff @(posedge mi_clk) begin
        if (rst) begin
            state_q <= IDLE;
            label_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!empty && (head_label != '0)) begin
                        label_q <= head_label;
                        state_q <= SERVE;
                    end
                end
                SERVE: begin
                    if (rem != '0) begin
                        label_q <= rem;
                    end else if ((count_q > ONE_CNT) && (next_label != '0)) begin
                        label_q <= next_label;
                    end else begin
                        label_q <= '0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    label_q <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign full      = full_q;
    assign label_out = (state_q == SERVE) ? label_q : 5'b0;
    assign valid_out = |label_out;
    assign data_out  = empty ? '0 : mem_q[rd_ptr_q];

`ifdef MI_DROP_CNT_EN
    logic [7:0] drop_cnt_q;

    always_ff @(posedge mi_clk) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else if (drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_q <= drop_cnt_q + 8'd1;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_multicast_input_unit.sv
// tb/tb_multicast_input_unit.sv - scoreboard bench for multicast_input_unit at router_ID=6
module tb_multicast_input_unit;

    logic        mi_clk;
    logic        rst;
    logic        in_valid;
    logic [29:0] in_data;
    logic        full;
    logic [4:0]  label_out;
    logic [29:0] data_out;
    logic        valid_out;
    logic [4:0]  grant;
`ifdef MI_DROP_CNT_EN
    logic [7:0]  drop_cnt;
`endif

    multicast_input_unit #(
        .DEPTH(4), .WIDTH(2), .DATASIZE(30), .router_ID(6)
    ) dut (
        .mi_clk    (mi_clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .full      (full),
        .label_out (label_out),
        .data_out  (data_out),
        .valid_out (valid_out),
        .grant     (grant)
`ifdef MI_DROP_CNT_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    always #5 mi_clk = ~mi_clk;

    typedef struct packed {
        logic [4:0]  label;
        logic [29:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;

    // Router 6 sits at x=2, y=1.
    localparam logic [29:0] F_A = {16'h0040, 14'h0011};
    localparam logic [29:0] F_B = {16'h00E0, 14'h0222};
    localparam logic [29:0] F_C = {16'h0404, 14'h0333};
    localparam logic [29:0] F_D = {16'h0001, 14'h0044};
    localparam logic [29:0] F_E = {16'h8000, 14'h0055};
    localparam logic [29:0] F_Z = {16'h0000, 14'h0066};
    localparam logic [29:0] F_A2 = {16'h0040, 14'h0077};
    localparam logic [29:0] F_B2 = {16'h00E0, 14'h0188};

    always @(negedge mi_clk) begin
        if (!rst && valid_out) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL mon_unexpected label got=%b want=none", label_out);
            end else begin
                mon_e = exp_q.pop_front();
                if (label_out !== mon_e.label) begin
                    n_fail++;
                    $display("FAIL mon_label got=%b want=%b", label_out, mon_e.label);
                end
                n_tests++;
                if (data_out !== mon_e.data) begin
                    n_fail++;
                    $display("FAIL mon_data got=%h want=%h", data_out, mon_e.data);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge mi_clk);
        #1;
    endtask

    task automatic push_flit(input logic [29:0] d);
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
    endtask

    task automatic serve_cycle(input logic [4:0] g, input logic [4:0] lbl, input logic [29:0] d);
        exp_q.push_back({lbl, d});
        grant = g;
        step();
        grant = 5'b0;
    endtask

    initial begin
        mi_clk   = 1'b0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        grant    = 5'b0;
        step();
        step();
        rst = 1'b0;
        check("rst_label", 32'(label_out), 32'h0);
        check("rst_valid", 32'(valid_out), 32'h0);
        check("rst_full",  32'(full),      32'h0);
        check("rst_data",  32'(data_out),  32'h0);
`ifdef MI_DROP_CNT_EN
        check("rst_drop_cnt", 32'(drop_cnt), 32'h0);
`endif

        // single local destination, two-cycle latency
        push_flit(F_A);
        check("single_t1_valid", 32'(valid_out), 32'h0);
        step();
        serve_cycle(5'b00001, 5'b00001, F_A);
        check("single_done_label", 32'(label_out), 32'h0);
        check("single_empty_data", 32'(data_out), 32'h0);

        // multicast W+L+E served in two grants
        push_flit(F_B);
        step();
        serve_cycle(5'b00010, 5'b01011, F_B);
        serve_cycle(5'b01001, 5'b01001, F_B);
        check("mcast_done_valid", 32'(valid_out), 32'h0);

        // column N+S with a grant outside the label
        push_flit(F_C);
        step();
        serve_cycle(5'b00001, 5'b10100, F_C);
        serve_cycle(5'b00000, 5'b10100, F_C);
        serve_cycle(5'b10100, 5'b10100, F_C);
        check("col_done_valid", 32'(valid_out), 32'h0);

        // backpressure: four accepted, fifth ignored, then back-to-back service
        exp_q.push_back({5'b00001, F_A});
        exp_q.push_back({5'b00001, F_A});
        exp_q.push_back({5'b00001, F_A});
        in_valid = 1'b1;
        in_data = F_A; step();
        in_data = F_B; step();
        in_data = F_C; step();
        check("bp_full_at_3", 32'(full), 32'h0);
        in_data = F_D; step();
        check("bp_full_at_4", 32'(full), 32'h1);
        in_data = F_E; step();
        in_valid = 1'b0;
        check("bp_full_hold", 32'(full), 32'h1);
        serve_cycle(5'b00001, 5'b00001, F_A);
        check("bp_full_clear", 32'(full), 32'h0);
        serve_cycle(5'b01011, 5'b01011, F_B);
        serve_cycle(5'b10100, 5'b10100, F_C);
        serve_cycle(5'b00010, 5'b00010, F_D);
        check("bp_done_valid", 32'(valid_out), 32'h0);
        check("bp_done_data",  32'(data_out),  32'h0);
        step();
        check("bp_no_fifth", 32'(valid_out), 32'h0);

        // zero bitmap is dropped, following flit proceeds
        push_flit(F_Z);
        push_flit(F_A2);
        check("drop_gap_valid", 32'(valid_out), 32'h0);
        step();
        serve_cycle(5'b00001, 5'b00001, F_A2);
        check("drop_done_data", 32'(data_out), 32'h0);
`ifdef MI_DROP_CNT_EN
        check("drop_cnt_one", 32'(drop_cnt), 32'h1);
`endif

        // reset in the middle of a partially served flit
        push_flit(F_B2);
        push_flit(F_A);
        serve_cycle(5'b00010, 5'b01011, F_B2);
        check("mid_partial_label", 32'(label_out), 32'h09);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_label", 32'(label_out), 32'h0);
        check("mid_rst_full",  32'(full),      32'h0);
        check("mid_rst_data",  32'(data_out),  32'h0);
        step();
        check("mid_rst_idle_valid", 32'(valid_out), 32'h0);
        check("mid_rst_idle_data",  32'(data_out),  32'h0);
`ifdef MI_DROP_CNT_EN
        check("mid_rst_drop_cnt", 32'(drop_cnt), 32'h0);
`endif
        step();
        check("scoreboard_drain", 32'(exp_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
